fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 7 +
 rtl/fetch_queue.sv | 36 +++
 rtl/fetch_unit.sv | 65 ++++++
 tb/tb_fetch_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants and the fetch state type
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic {RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: parameterized synchronous FIFO with flush, head read combinationally
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    always_ff @(posedge clk)
        if (push) mem[tail] <= wdata;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign data = mem[head];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner feeding decode through a small fetch queue,
// with redirect flush and a sticky halt on misaligned targets
import riscv_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        halted
);
    fetch_state_e state, state_next;
    logic [XLEN-1:0] pc;
    logic push, pop, flush, full, empty;
    logic [$clog2(QDEPTH):0] count;
    logic [63:0] head;
    logic misaligned;

    assign imem_addr = {2'b00, pc[31:2]};
    assign misaligned = redirect_pc[1:0] != 2'b00;
    // A redirect in HALT is ignored; the queue is already empty there.
    assign flush = redirect_valid && state == RUN;
    assign inst_valid = count != '0 && !redirect_valid;
    assign pop = inst_valid && inst_ready;
    assign push = state == RUN && !redirect_valid && (!full || pop);
    assign inst = empty ? INSTR_NOP : head[63:32];
    assign inst_pc = empty ? 32'h0 : head[31:0];
    assign halted = state == HALT;

    always_ff @(posedge clk)
        state <= reset ? RUN : state_next;

    always_comb begin
        state_next = state;
        if (flush && misaligned) state_next = HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) pc <= RESET_PC;
        else if (flush && !misaligned) pc <= redirect_pc;
        else if (push) pc <= pc + 32'd4;
    end

    fetch_queue #(.DEPTH(QDEPTH), .W(64)) u_queue (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(flush),
        .wdata({imem_rd, pc}),
        .data(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus checked against a queue-of-PCs reference model
module tb_fetch_unit;
    logic clk = 0;
    logic reset = 1;
    logic [31:0] imem_addr, imem_rd, redirect_pc = 0, inst, inst_pc;
    logic redirect_valid = 0, inst_valid, inst_ready = 0, halted;

    int compared = 0;
    int mismatched = 0;
    bit live = 0;

    logic [31:0] q[$];
    logic [31:0] mpc;
    bit mhalt;

    always #5 clk = ~clk;

    // Memory word k holds 0x1000 + k.
    assign imem_rd = 32'h1000 + imem_addr;

    fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_rd(imem_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        bit valid, popped;
        int sz;
        @(negedge clk);
        reset = r;
        redirect_valid = rv;
        redirect_pc = rpc;
        inst_ready = rdy;
        #1;
        valid = q.size() != 0 && !rv;
        if (live) begin
            chk("valid", inst_valid, valid);
            chk("inst_pc", inst_pc, q.size() != 0 ? q[0] : 32'h0);
            chk("inst", inst, q.size() != 0 ? 32'h1000 + (q[0] >> 2) : 32'h13);
            chk("halted", halted, mhalt);
            chk("imem_addr", imem_addr, mpc >> 2);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            mpc = 0;
            mhalt = 0;
            live = 1;
        end else if (rv && !mhalt) begin
            q.delete();
            if (rpc[1:0] == 2'b00) mpc = rpc;
            else mhalt = 1;
        end else begin
            sz = q.size();
            popped = valid && rdy;
            if (popped) void'(q.pop_front());
            if (!mhalt && (sz < 2 || popped)) begin
                q.push_back(mpc);
                mpc = mpc + 4;
            end
        end
    endtask

    initial begin
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h40, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h42, 1);
        for (int i = 0; i < 10; i++) cycle(0, i == 3, 32'h80, 1);
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            cycle(mhalt && $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, t,
                  $urandom_range(0, 3) != 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
